// File: rtl/mem_port_ctrl.sv
// Single-outstanding load/store port between a multicycle CPU controller and a
// valid/ready memory, with alignment checking and a bounded wait on the memory.
module mem_port_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              m_valid,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {StIdle, StReq, StWaitR, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              timeout_hit;

  // Cycle count since acceptance; the last allowed busy cycle has cnt_q == TIMEOUT-1.
  assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          err_q <= 1'b0;
          if (req_valid) begin
            if (req_addr[1:0] == 2'b00) begin
              we_q    <= req_we;
              addr_q  <= req_addr;
              wdata_q <= req_wdata;
              cnt_q   <= '0;
              state_q <= StReq;
            end else begin
              err_q   <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StReq: begin
          cnt_q <= cnt_q + CntW'(1);
          if (m_ready) begin
            state_q <= we_q ? StDone : StWaitR;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= StDone;
          end
        end
        StWaitR: begin
          cnt_q <= cnt_q + CntW'(1);
          if (m_rvalid) begin
            rdata_q <= m_rdata;
            state_q <= StDone;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q == StReq) || (state_q == StWaitR);
  assign m_valid   = (state_q == StReq);
  assign done      = (state_q == StDone);
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign m_we      = we_q;
  assign m_addr    = addr_q;
  assign m_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Randomized self-checking bench for mem_port_ctrl: each transaction's outcome
// (latency, err, rdata) is predicted from memory response delays chosen up front.
module tb_mem_port_ctrl;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, busy, done, err;
  logic [31:0] rdata;
  logic        m_valid, m_we;
  logic [31:0] m_addr, m_wdata;
  logic        m_ready, m_rvalid;
  logic [31:0] m_rdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_rdata;

  mem_port_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .m_valid   (m_valid),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_ready   (m_ready),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called #1 after an edge with the DUT idle. dr = REQ cycles without m_ready before
  // it is given; dv = WAIT_R cycles without m_rvalid before it is given.
  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input int dr, input int dv, input logic [31:0] rdv);
    bit mis, exp_err, hold, mv;
    int need, busy_n, done_c, rv_c;
    mis  = (addr[1:0] != 2'b00);
    hold = bit'($urandom % 2);
    if (mis) begin
      busy_n  = 0;
      exp_err = 1'b1;
    end else begin
      need = we ? dr + 1 : dr + dv + 2;
      if (need > T) begin
        busy_n  = T;
        exp_err = 1'b1;
      end else begin
        busy_n  = need;
        exp_err = 1'b0;
      end
    end
    done_c = busy_n + 1;
    rv_c   = dr + 2 + dv;

    check("idle_ready", req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    m_ready   = 1'(dr == 0 ? 0 : $urandom % 2) & mis;
    m_rvalid  = 1'($urandom % 2);
    m_rdata   = $urandom;

    for (int c = 1; c <= done_c; c++) begin
      @(posedge clk);
      #1;
      mv = !mis && (c <= busy_n) && (c <= dr + 1);
      check("busy", busy, !mis && (c <= busy_n));
      check("m_valid", m_valid, mv);
      check("done", done, c == done_c);
      check("err", err, (c == done_c) && exp_err);
      check("req_ready", req_ready, 0);
      if (mv) begin
        check("m_addr", m_addr, addr);
        check("m_we", m_we, we);
        check("m_wdata", m_wdata, wd);
      end
      if (c == done_c) begin
        if (!mis && !we && !exp_err) exp_rdata = rdv;
        check("rdata_done", rdata, exp_rdata);
      end else if (c == 1) begin
        check("rdata_hold", rdata, exp_rdata);
      end
      // Requests arriving while busy must be ignored.
      req_valid = hold;
      req_we    = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      if (mis) m_ready = 1'($urandom);
      else     m_ready = (c == dr + 1) || (c > dr + 1 && ($urandom % 2) == 1);
      m_rvalid = (!we && !mis && c == rv_c) ||
                 ((c <= dr + 1 || c >= done_c) && ($urandom % 4) == 0);
      m_rdata  = (c == rv_c) ? rdv : $urandom;
    end

    @(posedge clk);
    #1;
    check("post_ready", req_ready, 1);
    check("post_busy", busy, 0);
    check("post_done", done, 0);
    check("post_err", err, 0);
    check("post_rdata", rdata, exp_rdata);
    req_valid = 1'b0;
    m_ready   = 1'b0;
    m_rvalid  = 1'b0;
  endtask

  task automatic reset_mid_read();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h300;
    m_ready   = 1'b0;
    m_rvalid  = 1'b0;
    @(posedge clk); #1;
    check("rst_req_mvalid", m_valid, 1);
    req_valid = 1'b0;
    m_ready   = 1'b1;
    @(posedge clk); #1;
    check("rst_wait_busy", busy, 1);
    check("rst_wait_mvalid", m_valid, 0);
    m_ready = 1'b0;
    rst     = 1'b0;
    @(posedge clk); #1;
    exp_rdata = '0;
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, exp_rdata);
    rst      = 1'b1;
    m_rvalid = 1'b1;
    m_rdata  = 32'hAAAA5555;
    @(posedge clk); #1;
    check("late_rvalid_done", done, 0);
    check("late_rvalid_rdata", rdata, exp_rdata);
    check("late_rvalid_ready", req_ready, 1);
    m_rvalid = 1'b0;
  endtask

  task automatic random_txn();
    bit          we;
    logic [31:0] addr;
    int          r, dr, dv;
    we   = 1'($urandom);
    addr = $urandom & 32'hFFFF_FFFC;
    if ($urandom % 8 == 0) addr[1:0] = 2'(1 + $urandom % 3);
    r  = $urandom % 8;
    dr = (r == 0) ? T - 2 + int'($urandom % 4) : int'($urandom % 4);
    dv = (r == 1) ? T - 5 + int'($urandom % 4) : int'($urandom % 4);
    do_txn(we, addr, $urandom, dr, dv, $urandom);
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    m_ready   = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    exp_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", req_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_mvalid", m_valid, 0);
    check("reset_mwe", m_we, 0);
    check("reset_err", err, 0);
    check("reset_rdata", rdata, 0);
    check("reset_maddr", m_addr, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    do_txn(1'b1, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
    do_txn(1'b0, 32'h204, 32'h0, 3, 1, 32'h12345678);
    do_txn(1'b0, 32'h103, 32'h0, 0, 0, 32'h55);
    do_txn(1'b1, 32'h40, 32'h1, T, 0, 32'h0);
    do_txn(1'b1, 32'h44, 32'h2, T - 1, 0, 32'h0);
    do_txn(1'b0, 32'h48, 32'h0, 5, T - 7, 32'hCAFEF00D);
    do_txn(1'b0, 32'h4C, 32'h0, 5, T - 6, 32'h11111111);
    do_txn(1'b0, 32'h50, 32'h0, T, 0, 32'h22222222);

    for (int i = 0; i < 80; i++) random_txn();
    reset_mid_read();
    for (int i = 0; i < 80; i++) random_txn();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
